// File: rtl/billiard_pkg.sv
// Shared types for the billiard collision controller.
// Provides position/velocity types, the controller state encoding and ball-count limit.
package billiard_pkg;

    localparam int MAX_BALLS = 16;

    typedef logic [10:0]        pos_t;
    typedef logic signed [10:0] vel_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNAPSHOT = 3'd1,
        CHECK    = 3'd2,
        WRITE    = 3'd3,
        WALLS    = 3'd4,
        DONE     = 3'd5
    } coll_state_t;

endpackage

// File: rtl/ball_pair_check.sv
// Combinational test of one ball pair: overlap + approach, and the resolved velocities.
// Ports: xi/yi/xj/yj positions, vxi/vyi/vxj/vyj velocities in; hit, swap_x, new_v* out.
module ball_pair_check
    import billiard_pkg::*;
#(
    parameter int BALL_SIZE = 32
) (
    input  pos_t       xi,
    input  pos_t       yi,
    input  pos_t       xj,
    input  pos_t       yj,
    input  vel_t       vxi,
    input  vel_t       vyi,
    input  vel_t       vxj,
    input  vel_t       vyj,
    output logic       hit,
    output logic       swap_x,
    output vel_t       new_vxi,
    output vel_t       new_vyi,
    output vel_t       new_vxj,
    output vel_t       new_vyj
);

    localparam logic [23:0] HIT_LIM = 24'(BALL_SIZE * BALL_SIZE);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [11:0] dvx;
    logic signed [11:0] dvy;
    logic signed [23:0] sq_x;
    logic signed [23:0] sq_y;
    logic signed [23:0] pr_x;
    logic signed [23:0] pr_y;
    logic [23:0]        dist2;
    logic signed [24:0] dot;
    logic [11:0]        adx;
    logic [11:0]        ady;

    always_comb begin
        // zero-extend unsigned positions so the difference is a true signed delta
        dx    = {1'b0, xj} - {1'b0, xi};
        dy    = {1'b0, yj} - {1'b0, yi};
        dvx   = {vxj[10], vxj} - {vxi[10], vxi};
        dvy   = {vyj[10], vyj} - {vyi[10], vyi};
        sq_x  = dx * dx;
        sq_y  = dy * dy;
        pr_x  = dvx * dx;
        pr_y  = dvy * dy;
        dist2 = sq_x + sq_y;
        dot   = {pr_x[23], pr_x} + {pr_y[23], pr_y};
        adx   = dx[11] ? -dx : dx;
        ady   = dy[11] ? -dy : dy;
        // touching-but-separating pairs (dot >= 0) are left alone
        hit    = (dist2 < HIT_LIM) && dot[24];
        swap_x = (adx >= ady);
        new_vxi = swap_x ? vxj : vxi;
        new_vxj = swap_x ? vxi : vxj;
        new_vyi = swap_x ? vyi : vyj;
        new_vyj = swap_x ? vyj : vyi;
    end

endmodule

// File: rtl/ball_collision_ctrl.sv
// Per-frame collision controller: snapshots all balls on startOfFrame, scans every pair,
// and strobes resolved velocities back to the balls. Optional cushions: TABLE_WALLS_EN.
// Ports: clk, reset (sync, active high), startOfFrame, ballPos*/ballVel* per ball in;
//        velocityWriteEnable, outVelocityX/Y per ball, busy, scanDone out.
module ball_collision_ctrl
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS    = 4,
    parameter int BALL_SIZE    = 32,
    parameter int TABLE_LEFT   = 32,
    parameter int TABLE_RIGHT  = 608,
    parameter int TABLE_TOP    = 32,
    parameter int TABLE_BOTTOM = 448
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  pos_t                 ballPosX [NUM_BALLS],
    input  pos_t                 ballPosY [NUM_BALLS],
    input  vel_t                 ballVelX [NUM_BALLS],
    input  vel_t                 ballVelY [NUM_BALLS],
    output logic [NUM_BALLS-1:0] velocityWriteEnable,
    output vel_t                 outVelocityX [NUM_BALLS],
    output vel_t                 outVelocityY [NUM_BALLS],
    output logic                 busy,
    output logic                 scanDone
);

    localparam int IDX_W = $clog2(NUM_BALLS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_BALLS - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);

    coll_state_t      state;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;

    pos_t snap_x  [NUM_BALLS];
    pos_t snap_y  [NUM_BALLS];
    vel_t snap_vx [NUM_BALLS];
    vel_t snap_vy [NUM_BALLS];

    logic hit;
    logic swap_x;
    vel_t new_vxi;
    vel_t new_vyi;
    vel_t new_vxj;
    vel_t new_vyj;
    logic last_pair;
    logic scan_end;

    ball_pair_check #(
        .BALL_SIZE (BALL_SIZE)
    ) u_pair (
        .xi      (snap_x[idx_i]),
        .yi      (snap_y[idx_i]),
        .xj      (snap_x[idx_j]),
        .yj      (snap_y[idx_j]),
        .vxi     (snap_vx[idx_i]),
        .vyi     (snap_vy[idx_i]),
        .vxj     (snap_vx[idx_j]),
        .vyj     (snap_vy[idx_j]),
        .hit     (hit),
        .swap_x  (swap_x),
        .new_vxi (new_vxi),
        .new_vyi (new_vyi),
        .new_vxj (new_vxj),
        .new_vyj (new_vyj)
    );

    assign last_pair = (idx_i == LAST_I) && (idx_j == LAST);
    assign scan_end  = last_pair &&
                       ((state == CHECK && !hit) || state == WRITE);
    assign busy      = (state != IDLE);
    assign scanDone  = (state == DONE);

`ifdef TABLE_WALLS_EN
    logic [IDX_W-1:0] wall_idx;
    logic [IDX_W-1:0] wall_sel;
    logic             wall_apply;
    logic             flip_x;
    logic             flip_y;
    vel_t             wall_vx;
    vel_t             wall_vy;

    // Evaluate one ball ahead so its strobe lands in its own WALLS cycle.
    always_comb begin
        wall_sel   = (state == WALLS) ? wall_idx + 1'b1 : '0;
        wall_apply = scan_end || (state == WALLS && wall_idx != LAST);
        flip_x = ((int'(snap_x[wall_sel]) <= TABLE_LEFT) && (snap_vx[wall_sel] < 0)) ||
                 ((int'(snap_x[wall_sel]) + BALL_SIZE >= TABLE_RIGHT) &&
                  (snap_vx[wall_sel] > 0));
        flip_y = ((int'(snap_y[wall_sel]) <= TABLE_TOP) && (snap_vy[wall_sel] < 0)) ||
                 ((int'(snap_y[wall_sel]) + BALL_SIZE >= TABLE_BOTTOM) &&
                  (snap_vy[wall_sel] > 0));
        wall_vx = flip_x ? -snap_vx[wall_sel] : snap_vx[wall_sel];
        wall_vy = flip_y ? -snap_vy[wall_sel] : snap_vy[wall_sel];
    end
`else
    logic [31:0] unused_cushion;
    assign unused_cushion = TABLE_LEFT ^ TABLE_RIGHT ^ TABLE_TOP ^ TABLE_BOTTOM;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            idx_i               <= '0;
            idx_j               <= IDX_W'(1);
            velocityWriteEnable <= '0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                snap_x[k]       <= '0;
                snap_y[k]       <= '0;
                snap_vx[k]      <= '0;
                snap_vy[k]      <= '0;
                outVelocityX[k] <= '0;
                outVelocityY[k] <= '0;
            end
`ifdef TABLE_WALLS_EN
            wall_idx <= '0;
`endif
        end else begin
            velocityWriteEnable <= '0;
            unique case (state)
                IDLE: begin
                    if (startOfFrame) state <= SNAPSHOT;
                end
                SNAPSHOT: begin
                    for (int k = 0; k < NUM_BALLS; k++) begin
                        snap_x[k]  <= ballPosX[k];
                        snap_y[k]  <= ballPosY[k];
                        snap_vx[k] <= ballVelX[k];
                        snap_vy[k] <= ballVelY[k];
                    end
                    idx_i <= '0;
                    idx_j <= IDX_W'(1);
                    state <= CHECK;
                end
                CHECK: begin
                    if (hit) begin
                        velocityWriteEnable[idx_i] <= 1'b1;
                        velocityWriteEnable[idx_j] <= 1'b1;
                        outVelocityX[idx_i] <= new_vxi;
                        outVelocityY[idx_i] <= new_vyi;
                        outVelocityX[idx_j] <= new_vxj;
                        outVelocityY[idx_j] <= new_vyj;
                        // later pairs must see the post-collision velocities
                        snap_vx[idx_i] <= new_vxi;
                        snap_vy[idx_i] <= new_vyi;
                        snap_vx[idx_j] <= new_vxj;
                        snap_vy[idx_j] <= new_vyj;
                        state <= WRITE;
                    end else if (!last_pair) begin
                        if (idx_j == LAST) begin
                            idx_i <= idx_i + 1'b1;
                            idx_j <= idx_i + 1'b1 + 1'b1;
                        end else begin
                            idx_j <= idx_j + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state <= CHECK;
                    if (!last_pair) begin
                        if (idx_j == LAST) begin
                            idx_i <= idx_i + 1'b1;
                            idx_j <= idx_i + 1'b1 + 1'b1;
                        end else begin
                            idx_j <= idx_j + 1'b1;
                        end
                    end
                end
                WALLS: begin
`ifdef TABLE_WALLS_EN
                    if (wall_idx == LAST) state <= DONE;
                    else wall_idx <= wall_idx + 1'b1;
`else
                    state <= DONE;
`endif
                end
                DONE: begin
                    idx_i <= '0;
                    idx_j <= IDX_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef TABLE_WALLS_EN
            if (scan_end) begin
                state    <= WALLS;
                wall_idx <= '0;
            end
            if (wall_apply && (flip_x || flip_y)) begin
                velocityWriteEnable[wall_sel] <= 1'b1;
                outVelocityX[wall_sel] <= wall_vx;
                outVelocityY[wall_sel] <= wall_vy;
                snap_vx[wall_sel]      <= wall_vx;
                snap_vy[wall_sel]      <= wall_vy;
            end
`else
            if (scan_end) state <= DONE;
`endif
        end
    end

endmodule

// File: tb/tb_ball_collision_ctrl.sv
// Directed bench for ball_collision_ctrl with a queue of expected write strobes.
// Covers reset, head-on hits, separating/far pairs, y-axis swap, chained hits, mid-scan reset.
module tb_ball_collision_ctrl;
    import billiard_pkg::*;

    localparam int N = 4;
`ifdef TABLE_WALLS_EN
    localparam int WX = N;
`else
    localparam int WX = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         sof;
    pos_t         px [N];
    pos_t         py [N];
    vel_t         vx [N];
    vel_t         vy [N];
    logic [N-1:0] we;
    vel_t         ovx [N];
    vel_t         ovy [N];
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [N-1:0]       mask;
        logic [N-1:0][10:0] vx;
        logic [N-1:0][10:0] vy;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad   = 0;

    ball_collision_ctrl #(.NUM_BALLS(N)) dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (sof),
        .ballPosX            (px),
        .ballPosY            (py),
        .ballVelX            (vx),
        .ballVelY            (vy),
        .velocityWriteEnable (we),
        .outVelocityX        (ovx),
        .outVelocityY        (ovy),
        .busy                (busy),
        .scanDone            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input int k, input int x, input int y,
                         input int vxv, input int vyv);
        px[k] = 11'(x);
        py[k] = 11'(y);
        vx[k] = 11'(vxv);
        vy[k] = 11'(vyv);
    endtask

    // far apart, stationary, clear of the cushions
    task automatic park();
        place(0, 300, 200, 0, 0);
        place(1, 400, 200, 0, 0);
        place(2, 300, 350, 0, 0);
        place(3, 400, 350, 0, 0);
    endtask

    task automatic push_exp(input logic [N-1:0] m,
                            input int a, input int avx, input int avy,
                            input int b, input int bvx, input int bvy);
        wr_t e;
        e = '0;
        e.mask  = m;
        e.vx[a] = 11'(avx);
        e.vy[a] = 11'(avy);
        e.vx[b] = 11'(bvx);
        e.vy[b] = 11'(bvy);
        q.push_back(e);
    endtask

    task automatic run_frame(input string tag, input int exp_cyc, input bit sof_mid);
        wr_t e;
        int  cyc;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        cyc = 1;
        chk({tag, "_busy"}, int'(busy), 1);
        while (cyc < 60) begin
            if (sof_mid) sof = (cyc == 3);
            tick();
            cyc++;
            if (we != '0) begin
                if (q.size() == 0) begin
                    chk({tag, "_spurious_we"}, int'(we), 0);
                end else begin
                    e = q.pop_front();
                    chk({tag, "_we"}, int'(we), int'(e.mask));
                    for (int k = 0; k < N; k++) begin
                        if (e.mask[k]) begin
                            chk({tag, "_vx"}, int'(ovx[k]), int'($signed(e.vx[k])));
                            chk({tag, "_vy"}, int'(ovy[k]), int'($signed(e.vy[k])));
                        end
                    end
                end
            end
            if (done) break;
        end
        sof = 1'b0;
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_pending"}, q.size(), 0);
        q.delete();
        tick();
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_we_low"}, int'(we), 0);
    endtask

    initial begin
        reset = 1'b1;
        sof   = 1'b0;
        park();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovx0", int'(ovx[0]), 0);
        chk("rst_ovy3", int'(ovy[3]), 0);

        // head-on along x
        park();
        place(0, 100, 100, 5, 0);
        place(1, 120, 100, -3, 0);
        push_exp(4'b0011, 0, -3, 0, 1, 5, 0);
        run_frame("t1", 1 + 6 + 1 + 1 + WX, 1'b0);
        chk("t1_hold_vx0", int'(ovx[0]), -3);
        chk("t1_hold_vx1", int'(ovx[1]), 5);

        // separating, plus a startOfFrame mid-scan that must be ignored
        park();
        place(0, 100, 100, -5, 0);
        place(1, 120, 100, 3, 0);
        run_frame("t2", 1 + 6 + 1 + WX, 1'b1);
        chk("t2_no_restart", int'(busy), 0);

        // approaching but far apart
        park();
        place(0, 100, 100, 5, 0);
        place(1, 200, 100, -3, 0);
        run_frame("t3", 1 + 6 + 1 + WX, 1'b0);

        // |dy| > |dx|: swap vy only
        park();
        place(0, 100, 100, 1, 4);
        place(1, 104, 120, 1, -2);
        push_exp(4'b0011, 0, 1, -2, 1, 1, 4);
        run_frame("t4", 1 + 6 + 1 + 1 + WX, 1'b0);

        // chained: second pair only hits with the first pair's resolved velocity
        park();
        place(0, 100, 100, 5, 0);
        place(1, 120, 100, -3, 0);
        place(2, 80, 100, 0, 0);
        push_exp(4'b0011, 0, -3, 0, 1, 5, 0);
        push_exp(4'b0101, 0, 0, 0, 2, -3, 0);
        run_frame("t7", 1 + 6 + 2 + 1 + WX, 1'b0);

        // reset while in CHECK with a hit pending
        park();
        place(0, 100, 100, 5, 0);
        place(1, 120, 100, -3, 0);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_we", int'(we), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_ovx0", int'(ovx[0]), 0);
        tick();
        chk("t5_we_after", int'(we), 0);
        push_exp(4'b0011, 0, -3, 0, 1, 5, 0);
        run_frame("t5_rescan", 1 + 6 + 1 + 1 + WX, 1'b0);

        // ball against the left cushion
        park();
        place(2, 32, 200, -6, 0);
`ifdef TABLE_WALLS_EN
        push_exp(4'b0100, 2, 6, 0, 2, 6, 0);
`endif
        run_frame("t6", 1 + 6 + 1 + WX, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
